// File: rtl/usb_nrzi_tx_if.sv
// Word handshake between the packet framer (master) and the USB line transmitter (slave).
interface usb_nrzi_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;

  modport master (output data_in, output data_valid, output data_last, input data_ready);
  modport slave  (input data_in, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/usb_nrzi_tx.sv
// USB LS/FS line transmitter: SYNC, LSB-first NRZI with bit stuffing, configurable EOP.
//   state     | meaning
//   S_IDLE    | line J, waiting for the first word of a packet
//   S_SYNC    | driving the 8 SYNC bits (0000000 1)
//   S_DATA    | driving one data bit per cycle, reloading at word boundaries
//   S_STUFF   | inserted 0 after STUFF_LEN consecutive 1s
//   S_EOP_SE0 | EOP_SE0_CYC cycles of SE0
//   S_EOP_J   | final J of EOP
module usb_nrzi_tx #(
  parameter int DATA_W      = 8,
  parameter int STUFF_LEN   = 6,
  parameter int EOP_SE0_CYC = 2,
  parameter int SEND_SYNC   = 1
) (
  input  logic           clk,
  input  logic           rst_L,
  usb_nrzi_tx_if.slave   s_if,
  output logic           d_p,
  output logic           d_m,
  output logic           sending,
  output logic           underrun
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int EOP_W  = (EOP_SE0_CYC > 1) ? $clog2(EOP_SE0_CYC) : 1;
  localparam logic [ONES_W-1:0] ONES_TGT = ONES_W'(STUFF_LEN);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [EOP_W-1:0]  EOP_LOAD = EOP_W'(EOP_SE0_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_lvl, w_lvl_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_last, w_last_nxt;
  logic [ONES_W-1:0]   r_ones, w_ones_nxt;
  logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]          r_sync_cnt, w_sync_cnt_nxt;
  logic [EOP_W-1:0]    r_eop_cnt, w_eop_cnt_nxt;
  logic                r_to_eop, w_to_eop_nxt;

  logic                w_bit, w_nrzi, w_boundary, w_accept, w_stuff_due;
  logic [ONES_W-1:0]   w_ones_inc;

  always_comb begin
    case (r_state)
      S_SYNC:  w_bit = (r_sync_cnt == 3'd7);
      S_DATA:  w_bit = r_shift[0];
      default: w_bit = 1'b1;
    endcase
  end

  // r_lvl = 1 means J; a 0 bit toggles the line, a 1 bit holds it
  assign w_nrzi      = w_bit ? r_lvl : ~r_lvl;
  assign w_boundary  = (r_state == S_DATA) && (r_bit_cnt == BIT_LAST);
  assign w_ones_inc  = r_ones + 1'b1;
  assign w_stuff_due = w_bit && (w_ones_inc == ONES_TGT);

  assign s_if.data_ready = (r_state == S_IDLE) || (w_boundary && !r_last);
  assign w_accept        = s_if.data_valid && s_if.data_ready;
  assign underrun        = w_boundary && !r_last && !s_if.data_valid;
  assign sending         = (r_state != S_IDLE);

  always_comb begin
    d_p = 1'b1;
    d_m = 1'b0;
    case (r_state)
      S_SYNC, S_DATA: begin d_p = w_nrzi; d_m = ~w_nrzi; end
      S_STUFF:        begin d_p = ~r_lvl; d_m = r_lvl;   end
      S_EOP_SE0:      begin d_p = 1'b0;   d_m = 1'b0;    end
      default:        begin d_p = 1'b1;   d_m = 1'b0;    end
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lvl_nxt      = r_lvl;
    w_shift_nxt    = r_shift;
    w_last_nxt     = r_last;
    w_ones_nxt     = r_ones;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sync_cnt_nxt = r_sync_cnt;
    w_to_eop_nxt   = r_to_eop;
    w_eop_cnt_nxt  = EOP_LOAD;
    case (r_state)
      S_IDLE: begin
        w_lvl_nxt = 1'b1;
        if (w_accept) begin
          w_shift_nxt    = s_if.data_in;
          w_last_nxt     = s_if.data_last;
          w_ones_nxt     = '0;
          w_bit_cnt_nxt  = '0;
          w_sync_cnt_nxt = '0;
          w_to_eop_nxt   = 1'b0;
          w_state_nxt    = (SEND_SYNC != 0) ? S_SYNC : S_DATA;
        end
      end
      S_SYNC: begin
        w_lvl_nxt      = w_nrzi;
        w_ones_nxt     = w_bit ? w_ones_inc : '0;
        w_sync_cnt_nxt = r_sync_cnt + 3'd1;
        if (w_stuff_due)               w_state_nxt = S_STUFF;
        else if (r_sync_cnt == 3'd7)   w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_lvl_nxt     = w_nrzi;
        w_ones_nxt    = w_bit ? w_ones_inc : '0;
        w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (w_boundary) begin
          w_bit_cnt_nxt = '0;
          if (w_accept) begin
            w_shift_nxt  = s_if.data_in;
            w_last_nxt   = s_if.data_last;
            w_to_eop_nxt = 1'b0;
            w_state_nxt  = w_stuff_due ? S_STUFF : S_DATA;
          end else begin
            // last word done or underrun: a pending stuff still goes out before EOP
            w_to_eop_nxt = 1'b1;
            w_state_nxt  = w_stuff_due ? S_STUFF : S_EOP_SE0;
          end
        end else if (w_stuff_due) begin
          w_state_nxt = S_STUFF;
        end
      end
      S_STUFF: begin
        w_lvl_nxt   = ~r_lvl;
        w_ones_nxt  = '0;
        w_state_nxt = r_to_eop ? S_EOP_SE0 : S_DATA;
      end
      S_EOP_SE0: begin
        w_eop_cnt_nxt = r_eop_cnt - 1'b1;
        if (r_eop_cnt == '0) w_state_nxt = S_EOP_J;
      end
      S_EOP_J: begin
        w_lvl_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_lvl_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state    <= S_IDLE;
      r_lvl      <= 1'b1;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_ones     <= '0;
      r_bit_cnt  <= '0;
      r_sync_cnt <= '0;
      r_eop_cnt  <= EOP_LOAD;
      r_to_eop   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lvl      <= w_lvl_nxt;
      r_shift    <= w_shift_nxt;
      r_last     <= w_last_nxt;
      r_ones     <= w_ones_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_eop_cnt  <= w_eop_cnt_nxt;
      r_to_eop   <= w_to_eop_nxt;
    end
  end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Bench for usb_nrzi_tx: default-parameter and alternate-parameter instances against a list-based line model.
module tb_usb_nrzi_tx;

  logic clk = 1'b0;
  logic rst_L;
  always #5 clk = ~clk;

  logic       tb_sel;
  logic [7:0] tb_data;
  logic       tb_last;
  logic       tb_valid;

  usb_nrzi_tx_if #(.DATA_W(8)) if0 ();
  usb_nrzi_tx_if #(.DATA_W(8)) if1 ();

  assign if0.data_in    = tb_data;
  assign if0.data_last  = tb_last;
  assign if0.data_valid = tb_valid && !tb_sel;
  assign if1.data_in    = tb_data;
  assign if1.data_last  = tb_last;
  assign if1.data_valid = tb_valid && tb_sel;

  logic dp0, dm0, s0, u0, dp1, dm1, s1, u1;

  usb_nrzi_tx dut0 (
    .clk(clk), .rst_L(rst_L), .s_if(if0.slave),
    .d_p(dp0), .d_m(dm0), .sending(s0), .underrun(u0)
  );

  usb_nrzi_tx #(.DATA_W(8), .STUFF_LEN(3), .EOP_SE0_CYC(3), .SEND_SYNC(0)) dut1 (
    .clk(clk), .rst_L(rst_L), .s_if(if1.slave),
    .d_p(dp1), .d_m(dm1), .sending(s1), .underrun(u1)
  );

  logic m_dp, m_dm, m_send, m_und, m_rdy;
  assign m_dp   = tb_sel ? dp1 : dp0;
  assign m_dm   = tb_sel ? dm1 : dm0;
  assign m_send = tb_sel ? s1  : s0;
  assign m_und  = tb_sel ? u1  : u0;
  assign m_rdy  = tb_sel ? if1.data_ready : if0.data_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] pkt [8];
  int         pkt_n;
  bit         pkt_abort;
  logic [4:0] exp_q [$];   // {d_p, d_m, sending, data_ready, underrun} per cycle

  // Line model: list of bits -> stuffing -> NRZI levels -> EOP appended
  task automatic build_model();
    bit   bits [$];
    int   tags [$];
    int   sync_en, stuff_len, eop_len, ones;
    logic lvl, sym, r, u;
    bit   final_last;
    sync_en   = tb_sel ? 0 : 1;
    stuff_len = tb_sel ? 3 : 6;
    eop_len   = tb_sel ? 3 : 2;
    exp_q.delete();
    if (sync_en != 0) begin
      for (int i = 0; i < 7; i++) begin bits.push_back(1'b0); tags.push_back(0); end
      bits.push_back(1'b1); tags.push_back(0);
    end
    for (int w = 0; w < pkt_n; w++) begin
      final_last = (w == pkt_n - 1) && !pkt_abort;
      for (int b = 0; b < 8; b++) begin
        bits.push_back(pkt[w][b]);
        if (b == 7 && !final_last) tags.push_back((w == pkt_n - 1) ? 2 : 1);
        else tags.push_back(0);
      end
    end
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < bits.size(); i++) begin
      sym = bits[i] ? lvl : ~lvl;
      lvl = sym;
      r   = (tags[i] != 0);
      u   = (tags[i] == 2);
      exp_q.push_back({sym, ~sym, 1'b1, r, u});
      ones = bits[i] ? ones + 1 : 0;
      if (ones == stuff_len) begin
        lvl = ~lvl;
        exp_q.push_back({lvl, ~lvl, 1'b1, 1'b0, 1'b0});
        ones = 0;
      end
    end
    for (int e = 0; e < eop_len; e++) exp_q.push_back(5'b00100);
    exp_q.push_back(5'b10100);
  endtask

  // Starts from IDLE just after a rising edge; keeps data_valid high until the final word is taken
  task automatic run_packet(input string name, input int exp_len);
    int         widx, n_send;
    bit         acc;
    logic [4:0] got;
    build_model();
    tb_data  = pkt[0];
    tb_last  = (pkt_n == 1) && !pkt_abort;
    tb_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_dp, m_dm, m_send, m_rdy, m_und} !== 5'b10010)
      $display("FAIL %s idle-before: got %b expected %b", name, {m_dp, m_dm, m_send, m_rdy, m_und}, 5'b10010);
    @(posedge clk); #1;
    widx = 1;
    if (widx < pkt_n) begin tb_data = pkt[widx]; tb_last = (widx == pkt_n - 1) && !pkt_abort; end
    else tb_valid = 1'b0;
    n_send = 0;
    foreach (exp_q[c]) begin
      @(negedge clk);
      got = {m_dp, m_dm, m_send, m_rdy, m_und};
      checks++;
      if (got !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got dp,dm,send,rdy,und=%b expected %b", name, c, got, exp_q[c]);
      end
      if (m_send === 1'b1) n_send++;
      acc = tb_valid && m_rdy;
      @(posedge clk); #1;
      if (acc) begin
        widx++;
        if (widx < pkt_n) begin tb_data = pkt[widx]; tb_last = (widx == pkt_n - 1) && !pkt_abort; end
        else tb_valid = 1'b0;
      end
    end
    tb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_dp, m_dm, m_send, m_rdy, m_und} !== 5'b10010) begin
      errors++;
      $display("FAIL %s idle-after: got %b expected %b", name, {m_dp, m_dm, m_send, m_rdy, m_und}, 5'b10010);
    end
    if (exp_len != 0) begin
      checks++;
      if (n_send != exp_len) begin
        errors++;
        $display("FAIL %s sending-length: got %0d expected %0d", name, n_send, exp_len);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tb_sel = 1'b0; tb_valid = 1'b0; tb_data = '0; tb_last = 1'b0;
    rst_L = 1'b0;
    #12;
    checks++;
    if ({dp0, dm0, s0, if0.data_ready, u0, dp1, dm1, s1, if1.data_ready, u1} !== 10'b1001010010) begin
      errors++;
      $display("FAIL reset-values: got %b expected %b", {dp0, dm0, s0, if0.data_ready, u0, dp1, dm1, s1, if1.data_ready, u1}, 10'b1001010010);
    end
    @(negedge clk); rst_L = 1'b1;
    @(posedge clk); #1;
    tb_data = 8'hA5; tb_last = 1'b1; tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    checks++;
    if (m_send !== 1'b1) begin
      errors++;
      $display("FAIL reset-mid-packet-precondition: got sending=%b expected 1", m_send);
    end
    rst_L = 1'b0;
    #1;
    checks++;
    if ({m_dp, m_dm, m_send, m_rdy} !== 4'b1001) begin
      errors++;
      $display("FAIL reset-async: got dp,dm,send,rdy=%b expected 1001", {m_dp, m_dm, m_send, m_rdy});
    end
    repeat (2) @(posedge clk);
    #1 rst_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({m_dp, m_dm, m_send, m_und} !== 4'b1000) begin
        errors++;
        $display("FAIL reset-release cycle %0d: got dp,dm,send,und=%b expected 1000", i, {m_dp, m_dm, m_send, m_und});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_word();
    tb_sel = 1'b0; pkt[0] = 8'h00; pkt_n = 1; pkt_abort = 1'b0;
    run_packet("zero_word", 19);
  endtask

  task automatic test_ones_word();
    tb_sel = 1'b0; pkt[0] = 8'hFF; pkt_n = 1; pkt_abort = 1'b0;
    run_packet("ones_word", 20);
  endtask

  task automatic test_back_to_back();
    tb_sel = 1'b0; pkt[0] = 8'h01; pkt[1] = 8'h80; pkt_n = 2; pkt_abort = 1'b0;
    run_packet("back_to_back", 27);
  endtask

  task automatic test_underrun();
    tb_sel = 1'b0; pkt[0] = 8'h55; pkt_n = 1; pkt_abort = 1'b1;
    run_packet("underrun", 19);
  endtask

  task automatic test_alt_params();
    tb_sel = 1'b1; pkt[0] = 8'h0F; pkt_n = 1; pkt_abort = 1'b0;
    run_packet("alt_params", 13);
    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt_n = 2; pkt_abort = 1'b1;
    run_packet("alt_underrun_stuff", 0);
    tb_sel = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      tb_sel    = ($urandom_range(0, 1) == 1);
      pkt_n     = $urandom_range(1, 4);
      pkt_abort = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < pkt_n; w++) begin
        case ($urandom_range(0, 3))
          0:       pkt[w] = 8'hFF;
          1:       pkt[w] = 8'(8'hFC | $urandom_range(0, 3));
          default: pkt[w] = 8'($urandom_range(0, 255));
        endcase
      end
      run_packet("random", 0);
    end
    tb_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_ones_word();
    test_back_to_back();
    test_underrun();
    test_alt_params();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
